// File: rtl/counter_timer_ctrl.sv
// Interval-timer sequencer for an external registered up-counter.
// One-shot or periodic expiry ticks with a prescaler and start/stop control.
module counter_timer_ctrl #(
  parameter int unsigned COUNTER_WIDTH  = 8,
  parameter int unsigned PRESCALE_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      stop_i,
  input  logic                      mode_i,
  input  logic [COUNTER_WIDTH-1:0]  period_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  input  logic [COUNTER_WIDTH-1:0]  cntr_i,
  output logic                      cntr_rst_o,
  output logic                      cntr_en_o,
  output logic                      busy_o,
  output logic                      tick_o,
  output logic                      done_o,
  output logic                      err_o
);

  typedef enum logic [1:0] {StIdle, StClear, StRun} state_e;

  state_e                    r_state, w_state_d;
  logic [PRESCALE_WIDTH-1:0] r_pc, w_pc_d;
  logic [PRESCALE_WIDTH-1:0] r_prescale, w_prescale_d;
  logic [COUNTER_WIDTH-1:0]  r_period, w_period_d;
  logic                      r_mode, w_mode_d;
  logic                      r_busy, r_tick, r_done, r_err;
  logic                      w_tick_d, w_done_d, w_err_d;
  logic                      w_en_phase, w_term;

  // Terminal is judged on the value the counter holds during its last enable cycle.
  assign w_en_phase = (r_state == StRun) && (r_pc == r_prescale);
  assign w_term     = w_en_phase && (cntr_i == (r_period - COUNTER_WIDTH'(1)));

  always_comb begin
    cntr_rst_o = 1'b0;
    cntr_en_o  = 1'b0;
    if (!rst) begin
      unique case (r_state)
        StClear: cntr_rst_o = 1'b1;
        StRun: begin
          cntr_rst_o = stop_i || w_term;
          cntr_en_o  = w_en_phase && !w_term && !stop_i;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_pc_d       = r_pc;
    w_prescale_d = r_prescale;
    w_period_d   = r_period;
    w_mode_d     = r_mode;
    w_tick_d     = 1'b0;
    w_done_d     = 1'b0;
    w_err_d      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start_i) begin
          if (period_i != '0) begin
            w_state_d    = StClear;
            w_period_d   = period_i;
            w_prescale_d = prescale_i;
            w_mode_d     = mode_i;
          end else begin
            w_err_d = 1'b1;
          end
        end
      end
      StClear: begin
        w_pc_d    = '0;
        w_state_d = stop_i ? StIdle : StRun;
      end
      StRun: begin
        w_pc_d = (r_pc == r_prescale) ? '0 : r_pc + PRESCALE_WIDTH'(1);
        if (stop_i) begin
          w_state_d = StIdle;
        end else if (w_term) begin
          w_tick_d = 1'b1;
          if (!r_mode) begin
            w_done_d  = 1'b1;
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_pc       <= '0;
      r_prescale <= '0;
      r_period   <= '0;
      r_mode     <= 1'b0;
      r_busy     <= 1'b0;
      r_tick     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_pc       <= w_pc_d;
      r_prescale <= w_prescale_d;
      r_period   <= w_period_d;
      r_mode     <= w_mode_d;
      r_busy     <= (w_state_d != StIdle);
      r_tick     <= w_tick_d;
      r_done     <= w_done_d;
      r_err      <= w_err_d;
    end
  end

  assign busy_o = r_busy;
  assign tick_o = r_tick;
  assign done_o = r_done;
  assign err_o  = r_err;

endmodule
